// File: rtl/pattern_scan_pkg.sv
// Shared types and default sizing for the serial pattern-scan front end.
package pattern_scan_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_PAT_W  = 4;
   localparam int DEF_CNT_W  = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/pattern_match.sv
// Serial pattern matcher: history shift register, fill counter and comparator.
// z is combinational so a match is flagged in the same cycle as the bit
// that completes it.
module pattern_match
   import pattern_scan_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             x,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             z
);

   // Fill saturates at PAT_W-1: that many history bits plus x form a window.
   localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]  w_window;

   assign w_window = {r_hist, x};
   assign z        = en && (r_fill == FILL_FULL) && (w_window == pattern);

   // History/fill update; a non-overlapping match restarts the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (clr) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (en) begin
         r_hist <= w_window[PAT_W-2:0];
         if (z && !overlap) begin
            r_fill <= '0;
         end else if (r_fill != FILL_FULL) begin
            r_fill <= r_fill + FILL_W'(1);
         end else begin
            r_fill <= r_fill;
         end
      end else begin
         r_hist <= r_hist;
         r_fill <= r_fill;
      end
   end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scan controller: latches a word and pattern on start, shifts the word
// MSB-first into the matcher, counts matches and records the first one.
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PAT_W  = DEF_PAT_W,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int POS_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [PAT_W-1:0]  pattern,
   input  logic              overlap,
   output logic              busy,
   output logic              done,
   output logic              x_out,
   output logic              z_out,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              found,
   output logic [POS_W-1:0]  first_pos
);

   localparam logic [POS_W-1:0] LAST_IDX = POS_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t             r_state;
   logic [DATA_W-1:0]  r_word;
   logic [POS_W-1:0]   r_idx;
   logic [PAT_W-1:0]   r_pattern;
   logic               r_overlap;
   logic               r_busy;
   logic               r_done;
   logic               r_x;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_found;
   logic [POS_W-1:0]   r_pos;

   logic               w_accept;
   logic               w_shift;
   logic               w_z;

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_shift  = (r_state == ST_SHIFT);

   pattern_match #(
      .PAT_W (PAT_W)
   ) u_match (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_accept),
      .en      (w_shift),
      .x       (r_x),
      .pattern (r_pattern),
      .overlap (r_overlap),
      .z       (w_z)
   );

   // Scan sequencer: r_x holds the bit for the current index, r_word the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_word    <= '0;
         r_idx     <= '0;
         r_pattern <= '0;
         r_overlap <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_x       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_SHIFT;
                  r_x       <= data_in[DATA_W-1];
                  r_word    <= {data_in[DATA_W-2:0], 1'b0};
                  r_idx     <= '0;
                  r_pattern <= pattern;
                  r_overlap <= overlap;
                  r_busy    <= 1'b1;
               end else begin
                  r_busy <= 1'b0;
                  r_x    <= 1'b0;
               end
               r_done <= 1'b0;
            end
            ST_SHIFT: begin
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_DONE;
                  r_x     <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_x    <= r_word[DATA_W-1];
                  r_word <= {r_word[DATA_W-2:0], 1'b0};
                  r_idx  <= r_idx + POS_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_x     <= 1'b0;
            end
         endcase
      end
   end

   // Result bookkeeping: saturating match count and first-match position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_found <= 1'b0;
         r_pos   <= '0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_found <= 1'b0;
         r_pos   <= '0;
      end else if (w_z) begin
         if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= r_cnt;
         end
         if (!r_found) begin
            r_found <= 1'b1;
            r_pos   <= r_idx;
         end else begin
            r_pos <= r_pos;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign x_out     = r_x;
   assign z_out     = w_z;
   assign match_cnt = r_cnt;
   assign found     = r_found;
   assign first_pos = r_pos;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: a sliding-window model predicts
// every output each cycle; directed scans pin the model with literal values.
module tb_pattern_scan_ctrl;

   localparam int DW = 16;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] data_in;
   logic [PW-1:0] pattern;
   logic          overlap;

   logic          busy, done, x_out, z_out, found;
   logic [4:0]    match_cnt;
   logic [3:0]    first_pos;

   logic          b2_busy, b2_done, b2_x, b2_z, b2_found;
   logic [2:0]    b2_cnt;
   logic [3:0]    b2_pos;

   pattern_scan_ctrl dut (
      .clk (clk), .rst_n (rst_n), .start (start), .data_in (data_in),
      .pattern (pattern), .overlap (overlap), .busy (busy), .done (done),
      .x_out (x_out), .z_out (z_out), .match_cnt (match_cnt),
      .found (found), .first_pos (first_pos)
   );

   pattern_scan_ctrl #(.CNT_W (3)) dut_sat (
      .clk (clk), .rst_n (rst_n), .start (start), .data_in (data_in),
      .pattern (pattern), .overlap (overlap), .busy (b2_busy), .done (b2_done),
      .x_out (b2_x), .z_out (b2_z), .match_cnt (b2_cnt),
      .found (b2_found), .first_pos (b2_pos)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // model expectations
   logic exp_busy = 1'b0, exp_done = 1'b0, exp_x = 1'b0, exp_z = 1'b0, exp_found = 1'b0;
   int   exp_raw = 0;
   int   exp_fp  = 0;
   int   m_zmask = 0;
   int   d_zmask = 0;
   int   d_done_at = -1;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // per-cycle compare of both DUTs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", int'(busy), int'(exp_busy));
         chk("done", int'(done), int'(exp_done));
         chk("x_out", int'(x_out), int'(exp_x));
         chk("z_out", int'(z_out), int'(exp_z));
         chk("match_cnt", int'(match_cnt), sat(exp_raw, 31));
         chk("found", int'(found), int'(exp_found));
         chk("first_pos", int'(first_pos), exp_fp);
         chk("sat_busy", int'(b2_busy), int'(exp_busy));
         chk("sat_done", int'(b2_done), int'(exp_done));
         chk("sat_z", int'(b2_z), int'(exp_z));
         chk("sat_cnt", int'(b2_cnt), sat(exp_raw, 7));
         chk("sat_first_pos", int'(b2_pos), exp_fp);
      end
   end

   task automatic clear_model();
      exp_busy = 1'b0; exp_done = 1'b0; exp_x = 1'b0; exp_z = 1'b0;
      exp_found = 1'b0; exp_raw = 0; exp_fp = 0;
   endtask

   // One scan; abort_at >= 0 pulses reset while that index is on x_out.
   task automatic run_scan(input logic [DW-1:0] d, input logic [PW-1:0] p,
                           input logic ov, input bit hold, input int abort_at);
      int s;
      logic [PW-1:0] win;
      bit m;
      data_in = d; pattern = p; overlap = ov; start = 1'b1;
      @(posedge clk); #1;
      exp_raw = 0; exp_found = 1'b0; exp_fp = 0;
      m_zmask = 0; d_zmask = 0; d_done_at = -1; s = 0;
      // later input changes must not affect the latched scan
      data_in = DW'($urandom); pattern = PW'($urandom); overlap = 1'($urandom);
      if (!hold) start = 1'($urandom_range(0, 1));
      for (int i = 0; i < DW; i++) begin
         exp_busy = 1'b1; exp_done = 1'b0;
         exp_x = d[DW-1-i];
         win = PW'(d >> (DW-1-i));
         m = ((i - s) >= PW-1) && (win == p);
         exp_z = m;
         if (m) m_zmask = m_zmask | (1 << i);
         if (z_out) d_zmask = d_zmask | (1 << i);
         if (i == abort_at) begin
            #2;
            rst_n = 1'b0; start = 1'b0;
            clear_model();
            #1;
            chk("abort_busy", int'(busy), 0);
            chk("abort_x", int'(x_out), 0);
            chk("abort_z", int'(z_out), 0);
            chk("abort_cnt", int'(match_cnt), 0);
            chk("abort_found", int'(found), 0);
            chk("abort_pos", int'(first_pos), 0);
            #3;
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); #1;
            end
            return;
         end
         if (!hold) start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (m) begin
            exp_raw++;
            if (!exp_found) begin
               exp_found = 1'b1;
               exp_fp = i;
            end
            if (!ov) s = i + 1;
         end
      end
      exp_busy = 1'b1; exp_done = 1'b1; exp_x = 1'b0; exp_z = 1'b0;
      if (done) d_done_at = DW + 1;
      if (!hold) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      exp_busy = 1'b0; exp_done = 1'b0;
      if (!hold) start = 1'b0;
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [PW-1:0] p;
      rst_n = 1'b0; start = 1'b0; data_in = '0; pattern = '0; overlap = 1'b0;
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_x", int'(x_out), 0);
      chk("rst_z", int'(z_out), 0);
      chk("rst_cnt", int'(match_cnt), 0);
      chk("rst_found", int'(found), 0);
      chk("rst_pos", int'(first_pos), 0);
      chk_en = 1'b1;
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // single match at index 3
      run_scan(16'h6000, 4'b0110, 1'b0, 1'b0, -1);
      chk("t1_cnt", int'(match_cnt), 1);
      chk("t1_found", int'(found), 1);
      chk("t1_pos", int'(first_pos), 3);
      chk("t1_zmask", d_zmask, 32'h0008);
      chk("t1_model_zmask", m_zmask, 32'h0008);
      chk("t1_done_cycle", d_done_at, 17);
      idle(2);

      // all ones, overlapping
      run_scan(16'hFFFF, 4'b1111, 1'b1, 1'b0, -1);
      chk("t2_cnt", int'(match_cnt), 13);
      chk("t2_pos", int'(first_pos), 3);
      chk("t2_zmask", d_zmask, 32'hFFF8);
      chk("t2_model_cnt", exp_raw, 13);
      chk("t2_sat_cnt", int'(b2_cnt), 7);
      idle(1);

      // all ones, non-overlapping
      run_scan(16'hFFFF, 4'b1111, 1'b0, 1'b0, -1);
      chk("t3_cnt", int'(match_cnt), 4);
      chk("t3_zmask", d_zmask, 32'h8888);
      chk("t3_model_zmask", m_zmask, 32'h8888);
      idle(1);

      // no match, done still pulses
      run_scan(16'h0000, 4'b1001, 1'b0, 1'b0, -1);
      chk("t4_cnt", int'(match_cnt), 0);
      chk("t4_found", int'(found), 0);
      chk("t4_pos", int'(first_pos), 0);
      chk("t4_done_cycle", d_done_at, 17);
      idle(1);

      // mixed word: 1011 windows end at indices 10 and 13
      run_scan(16'b0110_1001_0110_1100, 4'b1011, 1'b1, 1'b0, -1);
      chk("t5_cnt", int'(match_cnt), 2);
      chk("t5_pos", int'(first_pos), 10);
      chk("t5_zmask", d_zmask, 32'h2400);
      chk("t5_model_zmask", m_zmask, 32'h2400);
      idle(1);

      // start held high: back-to-back scans, one per IDLE visit
      run_scan(16'hA5A5, 4'b0101, 1'b1, 1'b1, -1);
      run_scan(16'h3C3C, 4'b1100, 1'b0, 1'b1, -1);
      start = 1'b0;
      idle(2);

      // reset pulsed mid-scan, then a normal scan
      run_scan(16'hFFFF, 4'b1111, 1'b1, 1'b0, 8);
      run_scan(16'h6000, 4'b0110, 1'b0, 1'b0, -1);
      chk("post_abort_cnt", int'(match_cnt), 1);
      chk("post_abort_pos", int'(first_pos), 3);
      idle(1);

      // randomized scans
      for (int n = 0; n < 40; n++) begin
         d = DW'($urandom);
         if (n % 4 == 3) d = d & DW'($urandom);
         if ($urandom_range(0, 1) == 1) p = PW'(d >> $urandom_range(0, DW - PW));
         else p = PW'($urandom);
         run_scan(d, p, 1'($urandom), 1'b0, -1);
         idle($urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
